// File: rtl/photodiode_pkg.sv
// -----------------------------------------------------------------------------
// photodiode_pkg
//   Shared constants and helpers for the behavioural photodiode model.
//   Holds the default model parameters, the LFSR reset seed, a real-valued
//   clamp and the LFSR next-state function used when noise is compiled in.
// -----------------------------------------------------------------------------
package photodiode_pkg;

  // Default model parameters (volts / arbitrary optical units)
  localparam real RESP_DEF      = 0.5;     // responsivity, V per unit input
  localparam real DARK_DEF      = 0.001;   // dark-signal offset, V
  localparam real ALPHA_DEF     = 0.1;     // low-pass coefficient, (0.0, 1.0]
  localparam real VSAT_DEF      = 1.0;     // saturation voltage, V
  localparam real NOISE_AMP_DEF = 0.0001;  // peak-to-peak noise amplitude, V

  // Noise generator
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam real         LFSR_MAX  = 65535.0;

  // Limit v to [lo, hi]. The upper bound is applied first and the lower bound
  // last, so a degenerate hi < lo resolves to lo (the output never goes below
  // the floor).
  function automatic real clamp_r(input real v, input real lo, input real hi);
    real r;
    r = v;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // One step of a 16-bit Fibonacci LFSR, taps 16,14,13,11
  // (polynomial x^16 + x^14 + x^13 + x^11 + 1). Bits shift toward the LSB and
  // the feedback enters at the MSB, so the tap positions map to bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/photodiode_lpf.sv
// -----------------------------------------------------------------------------
// photodiode_lpf
//   First-order low-pass filter in double precision:
//     y <= y + ALPHA * (x - y)   on every rising clk edge with rst = 0
//     y <= 0.0                   on every rising clk edge with rst = 1
//
// Parameters
//   ALPHA : filter coefficient, legal range (0.0, 1.0]
//
// Ports
//   clk : sampling clock, rising edge active
//   rst : synchronous active-high reset, clears the filter state
//   x   : filter input (target value), sampled on the rising edge
//   y   : filter state, registered
// -----------------------------------------------------------------------------
module photodiode_lpf
  import photodiode_pkg::*;
#(
  parameter real ALPHA = ALPHA_DEF
) (
  input  logic clk,
  input  logic rst,
  input  real  x,
  output real  y
);

  real y_q;
  real y_d;

  // y + (x - y) is not always bit-exact x in floating point, so a unity
  // coefficient takes the input directly to guarantee a one-edge settle.
  always_comb begin
    y_d = y_q;
    if (ALPHA >= 1.0) begin
      y_d = x;
    end else begin
      y_d = y_q + ALPHA * (x - y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 0.0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/photodiode.sv
// -----------------------------------------------------------------------------
// photodiode
//   Behavioural photodiode front end. The optical input is rectified, scaled
//   by the responsivity, offset by the dark signal and limited to [0, VSAT].
//   The result is smoothed by a first-order low-pass filter; vout follows the
//   registered filter state with one clock of latency.
//
// Configuration
//   PHOTODIODE_NOISE_EN : when defined, a 16-bit LFSR adds a small noise term
//                         to vout (the filter state itself stays noise-free)
//                         and the NOISE_AMP parameter exists. When undefined,
//                         vout equals the filter state exactly and no LFSR
//                         is built.
//
// Parameters
//   RESP      : responsivity, volts per unit optical input
//   DARK      : dark-signal offset, volts
//   ALPHA     : low-pass coefficient, (0.0, 1.0]
//   VSAT      : saturation voltage, upper bound of vout
//   NOISE_AMP : peak-to-peak noise amplitude (PHOTODIODE_NOISE_EN only)
//
// Ports
//   clk  : sampling clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   vin  : optical input, real, arbitrary units
//   vout : modelled output voltage, real
// -----------------------------------------------------------------------------
module photodiode
  import photodiode_pkg::*;
#(
  parameter real RESP  = RESP_DEF,
  parameter real DARK  = DARK_DEF,
  parameter real ALPHA = ALPHA_DEF,
  parameter real VSAT  = VSAT_DEF
`ifdef PHOTODIODE_NOISE_EN
  ,
  parameter real NOISE_AMP = NOISE_AMP_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  real  vin,
  output real  vout
);

  real vin_c;
  real tgt;
  real filt;

  // Negative optical input is treated as darkness.
  always_comb begin
    vin_c = 0.0;
    if (vin > 0.0) begin
      vin_c = vin;
    end
    tgt = clamp_r(DARK + RESP * vin_c, 0.0, VSAT);
  end

  photodiode_lpf #(
    .ALPHA (ALPHA)
  ) u_lpf (
    .clk (clk),
    .rst (rst),
    .x   (tgt),
    .y   (filt)
  );

`ifdef PHOTODIODE_NOISE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  real         noise;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // The LFSR restarts from the same seed on every reset, so two runs that
  // share a reset produce the same noise sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Noise is centred on zero and spans NOISE_AMP peak to peak; the final
  // clamp keeps vout inside [0, VSAT] even with noise on top of a saturated
  // or dark filter state.
  always_comb begin
    noise = NOISE_AMP * (real'(lfsr_q) / LFSR_MAX - 0.5);
    vout  = clamp_r(filt + noise, 0.0, VSAT);
  end
`else
  assign vout = filt;
`endif

endmodule

// File: tb/tb_photodiode.sv
module tb_photodiode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  vin = 0.0;
  real  vout;

  int checks = 0;
  int errors = 0;

  localparam real RESP  = 0.5;
  localparam real DARK  = 0.001;
  localparam real ALPHA = 0.1;
  localparam real VSAT  = 1.0;

  photodiode dut (
    .clk  (clk),
    .rst  (rst),
    .vin  (vin),
    .vout (vout)
  );

  always #5 clk = ~clk;

  function automatic real fabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Target voltage straight from the transfer rules.
  function automatic real tgt_of(input real v);
    real t;
    t = DARK + RESP * ((v > 0.0) ? v : 0.0);
    if (t > VSAT) t = VSAT;
    if (t < 0.0)  t = 0.0;
    return t;
  endfunction

  // Closed-form first-order response after n edges at constant target.
  function automatic real settle(input real y0, input real t, input int n);
    return t + (y0 - t) * ((1.0 - ALPHA) ** real'(n));
  endfunction

  task automatic chk_near(input string tag, input real got, input real exp, input real tol);
    checks++;
    assert (fabs(got - exp) <= tol)
    else begin
      errors++;
      $error("FAIL %s: observed %.12f expected %.12f (tol %g)", tag, got, exp, tol);
    end
  endtask

  task automatic chk_le(input string tag, input real got, input real lim);
    checks++;
    assert (got <= lim)
    else begin
      errors++;
      $error("FAIL %s: observed %.12f expected <= %.12f", tag, got, lim);
    end
  endtask

  task automatic chk_ge(input string tag, input real got, input real lim);
    checks++;
    assert (got >= lim)
    else begin
      errors++;
      $error("FAIL %s: observed %.12f expected >= %.12f", tag, got, lim);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    real prev;
    real m;
`ifdef PHOTODIODE_NOISE_EN
    real seq1[$];
`endif

    #1;
    chk_near("pre_edge", vout, 0.0, 0.0);

`ifndef PHOTODIODE_NOISE_EN
    // Reset held for three edges, then release in the dark.
    rst = 1'b1;
    vin = 0.0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_near("in_reset", vout, 0.0, 0.0);
    end
    rst = 1'b0;
    tick(1);
    chk_near("dark_1st", vout, 0.0001, 1e-9);
    tick(199);
    chk_near("dark_200", vout, 0.001, 1e-6);

    // Unit step from reset; vin change must not show before the next edge.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vin = 1.0;
    #1;
    chk_near("latency_hold", vout, 0.0, 0.0);
    tick(1);
    chk_near("step_1st", vout, 0.0501, 1e-9);
    tick(1);
    chk_near("step_2nd", vout, 0.09519, 1e-9);
    tick(198);
    chk_near("step_200", vout, 0.501, 1e-6);
    chk_near("step_200_cf", vout, settle(0.0, tgt_of(1.0), 200), 1e-9);

    // Negative input: decay toward the dark level, never below it.
    vin  = -1.0;
    prev = vout;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      chk_ge("decay_floor", vout, 0.001);
      chk_le("decay_mono", vout, prev);
      prev = vout;
    end
    chk_near("decay_150_cf", vout, settle(0.501, 0.001, 150), 1e-9);

    // Heavy overdrive: saturate at VSAT without overshoot.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vin = 5.0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      chk_le("sat_bound", vout, 1.0);
    end
    chk_near("sat_300", vout, 1.0, 1e-6);

    // Reset in the middle of settling discards history.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vin = 1.0;
    tick(9);
    chk_near("mid_pre", vout, settle(0.0, 0.501, 9), 1e-9);
    chk_near("mid_near_0p3", vout, 0.3, 0.02);
    rst = 1'b1;
    tick(1);
    chk_near("mid_rst", vout, 0.0, 0.0);
    rst = 1'b0;
    vin = 1.0;
    tick(1);
    chk_near("mid_restart", vout, 0.0501, 1e-9);

    // Random input with occasional resets against the difference equation.
    rst = 1'b1;
    tick(1);
    m = 0.0;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      vin = real'($urandom_range(0, 6000)) / 1000.0 - 2.0;
      tick(1);
      if (rst) m = 0.0;
      else     m = m + ALPHA * (tgt_of(vin) - m);
      chk_near("rand", vout, m, 1e-12);
      chk_le("rand_vsat", vout, VSAT);
      chk_ge("rand_zero", vout, 0.0);
    end
    rst = 1'b0;
`else
    // Noise build: bounded noise around the dark level, repeatable per reset.
    rst = 1'b1;
    vin = 0.0;
    tick(3);
    chk_near("noise_rst", vout, 0.0, 0.0);
    rst = 1'b0;
    tick(300);
    for (int i = 0; i < 32; i++) begin
      tick(1);
      chk_near("noise_band", vout, 0.001, 0.00005 + 1e-12);
      seq1.push_back(vout);
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(300);
    for (int i = 0; i < 32; i++) begin
      tick(1);
      chk_near("noise_repeat", vout, seq1[i], 0.0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/photodiode.md
PHOTODIODE -- requirements
Module: photodiode

Interface
REQ-001 Parameter RESP, real, default 0.5: responsivity, output volts per unit of optical input.
REQ-002 Parameter DARK, real, default 0.001: dark-signal offset in volts, present at zero illumination.
REQ-003 Parameter ALPHA, real, default 0.1: first-order low-pass coefficient, legal range (0.0, 1.0].
REQ-004 Parameter VSAT, real, default 1.0: saturation voltage; the output upper bound.
REQ-005 Parameter NOISE_AMP, real, default 0.0001: peak-to-peak noise amplitude in volts; used only when noise is compiled in.
REQ-006 Port clk, input, 1 bit: sampling clock; all state updates occur on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port vin, input, real: optical input (irradiance proxy, arbitrary units).
REQ-009 Port vout, output, real: modelled photodiode output voltage.

Function
REQ-010 Each rising clk edge with rst=0 SHALL compute vin_c = max(vin, 0.0).
REQ-011 Target value SHALL be tgt = min(DARK + RESP*vin_c, VSAT), clamped below at 0.0.
REQ-012 Filter state SHALL update as filt <= filt + ALPHA*(tgt - filt), using vin sampled at that same edge.
REQ-013 vout SHALL be driven from registered state only; a change in vin SHALL first appear on vout after the next rising edge (one-cycle latency).
REQ-014 ALPHA=1.0 SHALL make filt equal tgt after exactly one edge.
REQ-015 With constant vin, vout SHALL converge monotonically to tgt; with vin <= 0 it SHALL converge to DARK.
REQ-016 vout SHALL never exceed VSAT and never fall below 0.0, including while noise is enabled.
REQ-017 All arithmetic SHALL be real (double precision); no quantisation is applied.

Reset
REQ-018 While rst=1 at a rising edge, filt SHALL become 0.0 and vout SHALL read 0.0 after that edge.
REQ-019 Reset asserted mid-settling SHALL discard filter history; filtering SHALL restart from 0.0 on the first edge with rst=0.
REQ-020 Before the first clock edge, vout SHALL read 0.0.

Configuration
REQ-021 Macro PHOTODIODE_NOISE_EN SHALL compile in a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) that advances once per non-reset edge.
REQ-022 With PHOTODIODE_NOISE_EN defined, vout SHALL equal clamp(filt + NOISE_AMP*(lfsr/65535.0 - 0.5), 0.0, VSAT); filt itself SHALL remain noise-free.
REQ-023 With PHOTODIODE_NOISE_EN undefined, vout SHALL equal filt exactly, and no LFSR logic SHALL exist.

Structure
REQ-024 Package photodiode_pkg SHALL hold the default constants (RESP, DARK, ALPHA, VSAT, NOISE_AMP), the LFSR seed, and a real clamp function.
REQ-025 The first-order filter SHALL be a sub-module photodiode_lpf (ports clk, rst, x, y, parameter ALPHA); the photodiode module SHALL instantiate it once.

Verification
REQ-026 Hold rst=1 for 3 edges, then release with vin=0.0 -> vout=0.0 during reset; 0.0001 after the 1st free edge; within 1e-6 of 0.001 after 200 edges.
REQ-027 From reset, step vin=1.0 -> vout=0.0501 after the 1st edge, 0.09519 after the 2nd, and within 1e-6 of 0.501 after 200 edges (tolerance 1e-9 on the early samples).
REQ-028 vin=5.0 held for 300 edges -> vout saturates to within 1e-6 of 1.0 and never exceeds 1.0.
REQ-029 vin=-1.0 after vout has settled at 0.501 -> vout decays toward 0.001 and stays >= 0.001.
REQ-030 Assert rst=1 for one edge while vout is about 0.3 -> vout=0.0 after that edge; the next free edge with vin=1.0 gives 0.0501.
REQ-031 With PHOTODIODE_NOISE_EN and vin=0.0 -> |vout - 0.001| <= 0.00005 once settled, and a value sequence identical across two runs that share the same reset.
